// File: rtl/gat_pkg.sv
// Shared constants and types for the GAT feature datapath.
// Holds the fixed sizing of the feature BRAM (element width, elements per
// vector, node count, read latency), the derived widths used by the
// fetcher, the fetcher state encoding and the node-to-base-address helper.
package gat_pkg;

    localparam int DATA_WIDTH         = 8;
    localparam int NUM_FEATURE_OUT    = 16;
    localparam int NUM_NODES          = 256;
    localparam int BRAM_RD_LAT        = 2;

    // Extra MSB on the node index so an out-of-range request is representable.
    localparam int NODE_W             = $clog2(NUM_NODES) + 1;
    localparam int NEW_FEATURE_WIDTH  = NUM_FEATURE_OUT * DATA_WIDTH;
    localparam int NEW_FEATURE_ADDR_W = $clog2(NUM_NODES * NUM_FEATURE_OUT);
    // One spare bit so a power-of-two element count does not wrap early.
    localparam int CNT_W              = $clog2(NUM_FEATURE_OUT) + 1;
    // Product width wide enough that idx*NUM_FEATURE_OUT never overflows
    // before truncation to the address width.
    localparam int PROD_W             = NODE_W + CNT_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } fetch_state_t;

    // First BRAM address of a node's feature vector, truncated to the
    // address width.
    function automatic logic [NEW_FEATURE_ADDR_W-1:0] node_base(
        input logic [NODE_W-1:0] idx
    );
        logic [PROD_W-1:0] prod;
        prod = PROD_W'(idx) * PROD_W'(NUM_FEATURE_OUT);
        return prod[NEW_FEATURE_ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/bram_rd_lat_pipe.sv
// Valid shift register that tracks reads in flight through the BRAM.
// A bit enters at din on every issued read and appears at tail exactly
// DEPTH cycles later, aligned with the returning read data.
// Ports:
//   clk   - clock
//   rst_n - asynchronous active-low reset, clears all stages
//   clr   - synchronous clear of all stages
//   din   - read issued this cycle
//   tail  - read data on the BRAM output is valid this cycle
module bram_rd_lat_pipe #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic din,
    output logic tail
);

    logic [DEPTH-1:0] stage_r;

    generate
        if (DEPTH == 1) begin : g_single
            // Single-stage pipe: register the issue flag directly.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stage_r <= 1'b0;
                end else if (clr) begin
                    stage_r <= 1'b0;
                end else begin
                    stage_r <= din;
                end
            end
        end else begin : g_multi
            // Multi-stage pipe: shift the issue flag one stage per cycle.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stage_r <= {DEPTH{1'b0}};
                end else if (clr) begin
                    stage_r <= {DEPTH{1'b0}};
                end else begin
                    stage_r <= {stage_r[DEPTH-2:0], din};
                end
            end
        end
    endgenerate

    assign tail = stage_r[DEPTH-1];

endmodule

// File: rtl/feature_fetcher.sv
// Feature vector fetcher: reads NUM_FEATURE_OUT consecutive words of one
// node from feature BRAM port B, packs them into a single vector and hands
// it downstream with a valid/ready handshake.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   req_node_idx        - node to fetch (extra MSB flags out-of-range)
//   req_vld / req_rdy   - request handshake, ready only while idle
//   req_err             - one-cycle pulse after accepting an out-of-range node
//   feat_bram_addrb     - BRAM read address
//   feat_bram_enb       - BRAM read enable
//   feat_bram_doutb     - BRAM read data, BRAM_RD_LAT cycles after enable
//   feat_out            - packed vector, element i at [i*DATA_WIDTH +: DATA_WIDTH]
//   feat_out_vld / _rdy - output handshake
module feature_fetcher
    import gat_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NODE_W-1:0]             req_node_idx,
    input  logic                          req_vld,
    output logic                          req_rdy,
    output logic                          req_err,
    output logic [NEW_FEATURE_ADDR_W-1:0] feat_bram_addrb,
    output logic                          feat_bram_enb,
    input  logic [DATA_WIDTH-1:0]         feat_bram_doutb,
    output logic [NEW_FEATURE_WIDTH-1:0]  feat_out,
    output logic                          feat_out_vld,
    input  logic                          feat_out_rdy
);

    localparam logic [CNT_W-1:0]              CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0]              CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]              CNT_LAST  = CNT_W'(NUM_FEATURE_OUT - 1);
    localparam logic [NEW_FEATURE_ADDR_W-1:0] ADDR_ZERO = NEW_FEATURE_ADDR_W'(0);
    localparam logic [NEW_FEATURE_ADDR_W-1:0] ADDR_ONE  = NEW_FEATURE_ADDR_W'(1);
    localparam logic [NODE_W-1:0]             NODE_LIM  = NODE_W'(NUM_NODES);

    fetch_state_t                  state_r, state_s;
    logic                          req_rdy_r, req_rdy_s;
    logic                          req_err_r, req_err_s;
    logic                          enb_r, enb_s;
    logic [NEW_FEATURE_ADDR_W-1:0] addr_r, addr_s;
    logic [CNT_W-1:0]              rd_cnt_r, rd_cnt_s;
    logic [CNT_W-1:0]              cap_cnt_r, cap_cnt_s;
    logic                          vld_r, vld_s;
    logic [NEW_FEATURE_WIDTH-1:0]  feat_r;
    logic                          tail_s;
    logic                          cap_done_s;
    logic                          idx_bad_s;
    logic                          pipe_clr_s;

    // Nothing is in flight while idle, so the pipe is held clear there.
    assign pipe_clr_s = (state_r == IDLE);

    bram_rd_lat_pipe #(
        .DEPTH (BRAM_RD_LAT)
    ) u_lat_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (pipe_clr_s),
        .din   (enb_r),
        .tail  (tail_s)
    );

    assign idx_bad_s  = (req_node_idx >= NODE_LIM);
    assign cap_done_s = tail_s && (cap_cnt_r == CNT_LAST);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state and next values of all registered control outputs.
    always_comb begin
        state_s   = state_r;
        req_rdy_s = req_rdy_r;
        req_err_s = 1'b0;
        enb_s     = enb_r;
        addr_s    = addr_r;
        rd_cnt_s  = rd_cnt_r;
        vld_s     = vld_r;

        // Returns can be captured in FETCH as well as DRAIN.
        if (tail_s) begin
            cap_cnt_s = cap_cnt_r + CNT_ONE;
        end else begin
            cap_cnt_s = cap_cnt_r;
        end

        case (state_r)
            IDLE: begin
                req_rdy_s = 1'b1;
                enb_s     = 1'b0;
                vld_s     = 1'b0;
                if (req_vld) begin
                    if (idx_bad_s) begin
                        req_err_s = 1'b1;
                    end else begin
                        // First read goes out the cycle after accept.
                        state_s   = FETCH;
                        req_rdy_s = 1'b0;
                        enb_s     = 1'b1;
                        addr_s    = node_base(req_node_idx);
                        rd_cnt_s  = CNT_ZERO;
                        cap_cnt_s = CNT_ZERO;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            FETCH: begin
                if (rd_cnt_r == CNT_LAST) begin
                    // Last read is on the bus now; address is left at the
                    // final word so the top node never wraps past the end.
                    state_s  = DRAIN;
                    enb_s    = 1'b0;
                    rd_cnt_s = rd_cnt_r;
                end else begin
                    rd_cnt_s = rd_cnt_r + CNT_ONE;
                    addr_s   = addr_r + ADDR_ONE;
                end
            end
            DRAIN: begin
                if (cap_done_s) begin
                    state_s = OUT;
                    vld_s   = 1'b1;
                end else begin
                    state_s = DRAIN;
                end
            end
            OUT: begin
                if (feat_out_rdy) begin
                    state_s   = IDLE;
                    vld_s     = 1'b0;
                    req_rdy_s = 1'b1;
                end else begin
                    vld_s = 1'b1;
                end
            end
            default: begin
                state_s   = IDLE;
                req_rdy_s = 1'b1;
                enb_s     = 1'b0;
                vld_s     = 1'b0;
            end
        endcase
    end

    // Registered control outputs and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_rdy_r <= 1'b1;
            req_err_r <= 1'b0;
            enb_r     <= 1'b0;
            addr_r    <= ADDR_ZERO;
            rd_cnt_r  <= CNT_ZERO;
            cap_cnt_r <= CNT_ZERO;
            vld_r     <= 1'b0;
        end else begin
            req_rdy_r <= req_rdy_s;
            req_err_r <= req_err_s;
            enb_r     <= enb_s;
            addr_r    <= addr_s;
            rd_cnt_r  <= rd_cnt_s;
            cap_cnt_r <= cap_cnt_s;
            vld_r     <= vld_s;
        end
    end

    // Write each returning word into its element slot of the output vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            feat_r <= {NEW_FEATURE_WIDTH{1'b0}};
        end else begin
            for (int i = 0; i < NUM_FEATURE_OUT; i++) begin
                if (tail_s && (cap_cnt_r == CNT_W'(i))) begin
                    feat_r[i*DATA_WIDTH +: DATA_WIDTH] <= feat_bram_doutb;
                end else begin
                    feat_r[i*DATA_WIDTH +: DATA_WIDTH] <= feat_r[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    assign req_rdy         = req_rdy_r;
    assign req_err         = req_err_r;
    assign feat_bram_enb   = enb_r;
    assign feat_bram_addrb = addr_r;
    assign feat_out        = feat_r;
    assign feat_out_vld    = vld_r;

endmodule

// File: tb/tb_feature_fetcher.sv
// Self-checking bench for feature_fetcher with a behavioural BRAM whose
// word at each address is the low byte of that address.
module tb_feature_fetcher;
    import gat_pkg::*;

    localparam int N   = NUM_FEATURE_OUT;
    localparam int LAT = BRAM_RD_LAT;
    localparam int MEM_DEPTH = NUM_NODES * NUM_FEATURE_OUT;

    logic                          clk;
    logic                          rst_n;
    logic [NODE_W-1:0]             req_node_idx;
    logic                          req_vld;
    logic                          req_rdy;
    logic                          req_err;
    logic [NEW_FEATURE_ADDR_W-1:0] feat_bram_addrb;
    logic                          feat_bram_enb;
    logic [DATA_WIDTH-1:0]         feat_bram_doutb;
    logic [NEW_FEATURE_WIDTH-1:0]  feat_out;
    logic                          feat_out_vld;
    logic                          feat_out_rdy;

    int total_cnt = 0;
    int bad_cnt   = 0;

    feature_fetcher dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_node_idx    (req_node_idx),
        .req_vld         (req_vld),
        .req_rdy         (req_rdy),
        .req_err         (req_err),
        .feat_bram_addrb (feat_bram_addrb),
        .feat_bram_enb   (feat_bram_enb),
        .feat_bram_doutb (feat_bram_doutb),
        .feat_out        (feat_out),
        .feat_out_vld    (feat_out_vld),
        .feat_out_rdy    (feat_out_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural BRAM: LAT-cycle registered read.
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] bram_pipe [LAT];

    initial begin
        for (int a = 0; a < MEM_DEPTH; a++) mem[a] = 8'(a);
    end

    always @(posedge clk) begin
        bram_pipe[0] <= mem[feat_bram_addrb];
        for (int i = 1; i < LAT; i++) bram_pipe[i] <= bram_pipe[i-1];
    end
    assign feat_bram_doutb = bram_pipe[LAT-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [NEW_FEATURE_WIDTH-1:0] exp_vec(input int node);
        logic [NEW_FEATURE_WIDTH-1:0] v;
        for (int i = 0; i < N; i++) v[i*DATA_WIDTH +: DATA_WIDTH] = mem[node*N + i];
        return v;
    endfunction

    // Scoreboard and protocol monitor, sampled on the falling edge.
    logic [NEW_FEATURE_WIDTH-1:0] sb_q [$];
    int  n_push = 0, n_pop = 0;
    int  exp_addr = 0, last_addr = -1;
    int  lat_cnt = 0, enb_cnt = 0;
    int  acc_cyc = 0, pop_cyc = 0;
    bit  tracking = 1'b0;
    bit  prev_vld = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
            n_pop    = n_push;
            tracking = 1'b0;
            prev_vld = 1'b0;
        end else begin
            if (tracking) lat_cnt++;
            if (tracking && feat_bram_enb) begin
                check("addrb", 128'(feat_bram_addrb), 128'(exp_addr));
                last_addr = int'(feat_bram_addrb);
                exp_addr++;
                enb_cnt++;
            end
            if (feat_out_vld && !prev_vld) begin
                check("vld_latency", 128'(lat_cnt), 128'(N + LAT + 1));
                check("enb_cycles", 128'(enb_cnt), 128'(N));
            end
            if (feat_out_vld && feat_out_rdy) begin
                if (sb_q.size() == 0) begin
                    check("sb_nonempty", 128'(sb_q.size()), 128'(1));
                end else begin
                    check("feat_out", 128'(feat_out), 128'(sb_q.pop_front()));
                end
                n_pop++;
                pop_cyc  = cyc;
                tracking = 1'b0;
            end
            if (req_vld && req_rdy && (int'(req_node_idx) < NUM_NODES)) begin
                sb_q.push_back(exp_vec(int'(req_node_idx)));
                exp_addr = int'(req_node_idx) * N;
                lat_cnt  = 0;
                enb_cnt  = 0;
                tracking = 1'b1;
                acc_cyc  = cyc;
                n_push++;
            end
            prev_vld = feat_out_vld;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_req(input int node);
        req_node_idx = NODE_W'(node);
        req_vld      = 1'b1;
        step();
        req_vld      = 1'b0;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 300; k++) begin
            if (n_pop == n_push && req_rdy) break;
            step();
        end
        check("drain", 128'(n_pop), 128'(n_push));
    endtask

    task automatic wait_vld();
        for (int k = 0; k < 60; k++) begin
            if (feat_out_vld) break;
            step();
        end
        check("vld_seen", 128'(feat_out_vld), 128'(1));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_req_rdy"}, 128'(req_rdy), 128'(1));
        check({tag, "_req_err"}, 128'(req_err), 128'(0));
        check({tag, "_enb"},     128'(feat_bram_enb), 128'(0));
        check({tag, "_addrb"},   128'(feat_bram_addrb), 128'(0));
        check({tag, "_feat"},    128'(feat_out), 128'(0));
        check({tag, "_vld"},     128'(feat_out_vld), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NEW_FEATURE_WIDTH-1:0] held;
        int pushes_before;

        rst_n        = 1'b0;
        req_vld      = 1'b0;
        req_node_idx = '0;
        feat_out_rdy = 1'b0;
        step();
        step();
        check_reset_vals("rst");
        rst_n = 1'b1;
        step();

        // Basic fetch of node 3 with the sink always ready.
        feat_out_rdy = 1'b1;
        send_req(3);
        wait_drain();
        check("node3_last_addr", 128'(last_addr), 128'(63));

        // Backpressure on node 0.
        feat_out_rdy = 1'b0;
        send_req(0);
        wait_vld();
        held = feat_out;
        for (int k = 0; k < 10; k++) begin
            step();
            check("bp_vld", 128'(feat_out_vld), 128'(1));
            check("bp_stable", 128'(feat_out), 128'(held));
            check("bp_req_rdy", 128'(req_rdy), 128'(0));
            check("bp_enb", 128'(feat_bram_enb), 128'(0));
        end
        feat_out_rdy = 1'b1;
        step();
        check("bp_vld_drop", 128'(feat_out_vld), 128'(0));
        check("bp_req_rdy_back", 128'(req_rdy), 128'(1));
        check("bp_popped", 128'(n_pop), 128'(n_push));

        // Highest valid node reaches the last BRAM address.
        send_req(NUM_NODES - 1);
        wait_drain();
        check("node255_last_addr", 128'(last_addr), 128'(MEM_DEPTH - 1));

        // Out-of-range node.
        pushes_before = n_push;
        send_req(NUM_NODES);
        check("err_pulse", 128'(req_err), 128'(1));
        check("err_req_rdy", 128'(req_rdy), 128'(1));
        check("err_enb0", 128'(feat_bram_enb), 128'(0));
        step();
        check("err_clear", 128'(req_err), 128'(0));
        for (int k = 0; k < 5; k++) begin
            check("err_no_enb", 128'(feat_bram_enb), 128'(0));
            check("err_rdy_hold", 128'(req_rdy), 128'(1));
            step();
        end
        check("err_no_push", 128'(n_push), 128'(pushes_before));

        // Reset in the middle of a fetch, then a clean fetch of node 1.
        send_req(3);
        for (int k = 0; k < 7; k++) step();
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        step();
        step();
        rst_n = 1'b1;
        check_reset_vals("postrst");
        send_req(1);
        wait_drain();

        // Back-to-back requests with req_vld held high.
        pushes_before = n_push;
        req_node_idx  = NODE_W'(5);
        req_vld       = 1'b1;
        step();
        req_node_idx  = NODE_W'(6);
        for (int k = 0; k < 100; k++) begin
            if (n_push == pushes_before + 2) break;
            step();
        end
        req_vld = 1'b0;
        check("b2b_accepts", 128'(n_push), 128'(pushes_before + 2));
        check("b2b_gap", 128'(acc_cyc), 128'(pop_cyc + 1));
        wait_drain();

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/feature_fetcher.md
Name: feature_fetcher

Overview:
- Read-side counterpart of the new-feature BRAM writer.
- On a node request, issues NUM_FEATURE_OUT sequential reads from the feature BRAM port B, starting at base address node_idx*NUM_FEATURE_OUT.
- Absorbs the fixed BRAM read latency and packs the returned words into one NEW_FEATURE_WIDTH vector.
- Presents the vector with a valid/ready handshake to the downstream aggregation stage.

Parameters:
- DATA_WIDTH, 8, width of one feature element.
- NUM_FEATURE_OUT, 16, elements per feature vector.
- NUM_NODES, 256, number of vectors stored in BRAM.
- BRAM_RD_LAT, 2, cycles from feat_bram_enb/addrb to valid feat_bram_doutb (≥1).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- req_node_idx  in  NODE_W=$clog2(NUM_NODES)+1  node to fetch (extra MSB allows out-of-range detection)
- req_vld  in  1  request valid
- req_rdy  out  1  fetcher can accept a request
- req_err  out  1  one-cycle pulse: accepted request had req_node_idx ≥ NUM_NODES
- feat_bram_addrb  out  NEW_FEATURE_ADDR_W=$clog2(NUM_NODES*NUM_FEATURE_OUT)  BRAM read address
- feat_bram_enb  out  1  BRAM read enable
- feat_bram_doutb  in  DATA_WIDTH  BRAM read data
- feat_out  out  NEW_FEATURE_WIDTH=NUM_FEATURE_OUT*DATA_WIDTH  packed vector; element i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- feat_out_vld  out  1  feat_out valid
- feat_out_rdy  in  1  downstream accepts

Behaviour:
- Reset values (async, rst_n low): state=IDLE, req_rdy=1, req_err=0, feat_bram_enb=0, feat_bram_addrb=0, feat_out=0, feat_out_vld=0; read counter, capture counter and latency pipe all cleared.
- Reset mid-operation abandons the fetch. Read data still returning from BRAM after reset release is ignored, because the latency pipe was cleared.
- FSM:
  - IDLE: req_rdy=1. On req_vld, latch the index.
    - Index ≥ NUM_NODES: pulse req_err next cycle, stay IDLE, no BRAM access.
    - Otherwise go to FETCH.
  - FETCH: feat_bram_enb=1 for exactly NUM_FEATURE_OUT consecutive cycles, addrb = base + rd_cnt (rd_cnt 0..N-1). After the last issue go to DRAIN.
  - DRAIN: wait until all BRAM_RD_LAT-delayed returns are captured, then go to OUT.
  - OUT: feat_out_vld=1, feat_out held stable. On feat_out_rdy, go to IDLE.
- req_rdy=1 only in IDLE. No overlap between requests.
- Timing: request accepted at cycle T → reads issued T+1..T+N → last data captured at T+N+BRAM_RD_LAT → feat_out_vld rises at T+N+BRAM_RD_LAT+1.
- If feat_out_rdy is already high when vld rises, the transfer completes that cycle and req_rdy=1 the following cycle.
- Capture:
  - A BRAM_RD_LAT-deep valid shift register tracks each issued read.
  - When its tail is high, write feat_bram_doutb into element cap_cnt, then increment cap_cnt.
  - cap_cnt reaching N-1 with the tail high completes the vector.
- Arithmetic:
  - base = req_node_idx*NUM_FEATURE_OUT, computed once at accept and truncated to NEW_FEATURE_ADDR_W.
  - Counters are $clog2(NUM_FEATURE_OUT)+1 bits wide so N = power of two does not wrap early.
- The last valid node (NUM_NODES-1) must reach address NUM_NODES*NUM_FEATURE_OUT-1 without overflow.
- feat_out_rdy high outside OUT is ignored. req_vld outside IDLE is ignored (not latched).

Decomposition:
- gat_pkg holds DATA_WIDTH, NUM_FEATURE_OUT, NUM_NODES, NEW_FEATURE_WIDTH, NEW_FEATURE_ADDR_W, BRAM_RD_LAT, and a fetch_state_t enum {IDLE, FETCH, DRAIN, OUT}.
- One natural sub-module: bram_rd_lat_pipe, a parameterised valid shift register of depth BRAM_RD_LAT with synchronous clear and async reset.

Test Plan:
- Basic fetch: BRAM preloaded with word = address[7:0]; request node 3, N=16, LAT=2, rdy held high → addrb 48..63 issued over 16 cycles; vld rises at T+19; feat_out element i = 48+i.
- Backpressure: request node 0, hold feat_out_rdy low for 10 cycles after vld → feat_out stable and vld high throughout; req_rdy=0; enb=0; transfer completes on the first rdy cycle.
- Boundary node: request node 255 → last addrb = 4095; vector equals BRAM words 4080..4095.
- Illegal index: request node 256 → req_err pulses exactly 1 cycle, enb never asserted, req_rdy stays 1.
- Reset mid-fetch: assert rst_n low at T+8, release at T+10 → all outputs at reset values; next request to node 1 returns correct words 16..31 with no stale elements.
- Back-to-back: req_vld held high with nodes 5 then 6, rdy high → second request accepted the cycle after the first transfer completes; outputs match BRAM contents for each node in order.
